// File: rtl/fetch_unit_pkg.sv
// Shared ISA and FSM definitions for the instruction-fetch stage.
// Holds the halt opcode, the fetch state encodings and an opcode field helper.
package fetch_unit_pkg;

   localparam logic [5:0] OP_HALT = 6'd63;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_WAIT   = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_NPC    = 3'd3,
      ST_HALTED = 3'd4,
      ST_ERROR  = 3'd5
   } fetch_state_t;

   function automatic logic [5:0] opcodeOf(input logic [31:0] insWord);
      return insWord[31:26];
   endfunction

endpackage

// File: rtl/fetch_unit_watchdog.sv
// Instruction-memory watchdog: counts cycles spent waiting for read data and
// flags the last permitted cycle. A timeout of zero disables it.
module fetch_watchdog #(
   parameter int unsigned IMEM_TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [31:0] LIMIT = (IMEM_TIMEOUT == 0) ? 32'd0 : 32'(IMEM_TIMEOUT - 1);

   logic [31:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign o_expire = (IMEM_TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// Single-issue, non-overlapped instruction fetch: one imem read per instruction,
// valid/ready hand-off to execute, then wait for execute's next PC.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'd0,
   parameter int unsigned IMEM_TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_ins,
   output logic [31:0] o_pc,
   output logic        o_ins_valid,
   input  logic        i_ins_ready,
   input  logic        i_npc_valid,
   input  logic [31:0] i_nextpc,
   output logic        o_halted,
   output logic        o_timeout,
   output logic [31:0] o_instret
);

   fetch_state_t r_state;
   logic         r_imemReq;
   logic [31:0]  r_imemAddr;
   logic [31:0]  r_ins;
   logic [31:0]  r_pc;
   logic         r_insValid;
   logic         r_halted;
   logic         r_timeout;
   logic [31:0]  r_instret;

   logic w_wdogClear;
   logic w_wdogEnable;
   logic w_wdogExpire;

   assign w_wdogClear  = (r_state != ST_WAIT);
   assign w_wdogEnable = (r_state == ST_WAIT) && !i_imem_rvalid;

   fetch_watchdog #(
      .IMEM_TIMEOUT(IMEM_TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_wdogClear),
      .i_enable (w_wdogEnable),
      .o_expire (w_wdogExpire)
   );

   // The read strobe is raised on the edge that enters FETCH, so the FETCH
   // cycle itself carries the request; only the post-reset FETCH has to arm it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_FETCH;
         r_imemReq  <= 1'b0;
         r_imemAddr <= RESET_PC;
         r_ins      <= '0;
         r_pc       <= RESET_PC;
         r_insValid <= 1'b0;
         r_halted   <= 1'b0;
         r_timeout  <= 1'b0;
         r_instret  <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (!r_imemReq) begin
                  r_imemReq  <= 1'b1;
                  r_imemAddr <= r_pc;
               end else begin
                  r_imemReq <= 1'b0;
                  r_state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_imem_rvalid) begin
                  r_ins      <= i_imem_rdata;
                  r_insValid <= 1'b1;
                  r_state    <= ST_ISSUE;
               end else if (w_wdogExpire) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_ERROR;
               end
            end
            ST_ISSUE: begin
               if (i_ins_ready) begin
                  r_insValid <= 1'b0;
                  r_instret  <= r_instret + 32'd1;
                  if (opcodeOf(r_ins) == OP_HALT) begin
                     r_halted <= 1'b1;
                     r_state  <= ST_HALTED;
                  end else if (i_npc_valid) begin
                     r_pc       <= i_nextpc;
                     r_imemAddr <= i_nextpc;
                     r_imemReq  <= 1'b1;
                     r_state    <= ST_FETCH;
                  end else begin
                     r_state <= ST_NPC;
                  end
               end
            end
            ST_NPC: begin
               if (i_npc_valid) begin
                  r_pc       <= i_nextpc;
                  r_imemAddr <= i_nextpc;
                  r_imemReq  <= 1'b1;
                  r_state    <= ST_FETCH;
               end
            end
            default: begin
               r_imemReq  <= 1'b0;
               r_insValid <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_req  = r_imemReq;
   assign o_imem_addr = r_imemAddr;
   assign o_ins       = r_ins;
   assign o_pc        = r_pc;
   assign o_ins_valid = r_insValid;
   assign o_halted    = r_halted;
   assign o_timeout   = r_timeout;
   assign o_instret   = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of straight-line fetches plus hand-written
// sequences for reset abort, stalls, PC wrap, halt and the imem watchdog.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic [31:0] ins;
   logic [31:0] pc;
   logic        insValid;
   logic        insReady;
   logic        npcValid;
   logic [31:0] nextpc;
   logic        halted;
   logic        timeout;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] nextpc;
      logic [31:0] expAddr;
      logic [31:0] expInstret;
   } vec_t;

   vec_t vecs[4];

   fetch_unit #(
      .RESET_PC     (32'h0000_0010),
      .IMEM_TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .o_imem_req    (imemReq),
      .o_imem_addr   (imemAddr),
      .i_imem_rvalid (imemRvalid),
      .i_imem_rdata  (imemRdata),
      .o_ins         (ins),
      .o_pc          (pc),
      .o_ins_valid   (insValid),
      .i_ins_ready   (insReady),
      .i_npc_valid   (npcValid),
      .i_nextpc      (nextpc),
      .o_halted      (halted),
      .o_timeout     (timeout),
      .o_instret     (instret)
   );

   // Free-running clock and a cycle counter used for latency/period checks.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One comparison: counts it and reports a mismatch with actual and required values.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      imemRvalid = 1'b0;
      imemRdata  = 32'h0;
      insReady   = 1'b0;
      npcValid   = 1'b0;
      nextpc     = 32'h0;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".imemReq"},  {31'd0, imemReq},  32'd0);
      checkOutput({tag, ".imemAddr"}, imemAddr,          32'h10);
      checkOutput({tag, ".ins"},      ins,               32'h0);
      checkOutput({tag, ".pc"},       pc,                32'h10);
      checkOutput({tag, ".insValid"}, {31'd0, insValid}, 32'd0);
      checkOutput({tag, ".halted"},   {31'd0, halted},   32'd0);
      checkOutput({tag, ".timeout"},  {31'd0, timeout},  32'd0);
      checkOutput({tag, ".instret"},  instret,           32'd0);
   endtask

   // Bounded wait (at negedges) for the read strobe; returns the cycle it was seen.
   task automatic waitReq(input string tag, output int reqCycle);
      int n = 0;
      while (imemReq !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, ".reqSeen"}, {31'd0, imemReq}, 32'd1);
      reqCycle = cyc;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst_n = 1'b0;
      idleInputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One complete instruction with a 1-cycle imem and same-edge ready/nextpc.
   task automatic applyStimulus(input vec_t v, input string tag, output int reqCycle);
      waitReq(tag, reqCycle);
      checkOutput({tag, ".imemAddr"}, imemAddr, v.expAddr);
      @(negedge clk);
      imemRvalid = 1'b1;
      imemRdata  = v.rdata;
      @(negedge clk);
      imemRvalid = 1'b0;
      checkOutput({tag, ".insValid"}, {31'd0, insValid}, 32'd1);
      checkOutput({tag, ".ins"},      ins,               v.rdata);
      checkOutput({tag, ".pc"},       pc,                v.expAddr);
      insReady = 1'b1;
      npcValid = 1'b1;
      nextpc   = v.nextpc;
      @(negedge clk);
      insReady = 1'b0;
      npcValid = 1'b0;
      checkOutput({tag, ".insValidDrop"}, {31'd0, insValid}, 32'd0);
      checkOutput({tag, ".instret"},      instret,           v.expInstret);
   endtask

   initial begin
      int r0;
      int r1;
      int rTmp;
      int reqSeen;

      vecs[0] = '{rdata: 32'h0421_0005, nextpc: 32'h0000_0011, expAddr: 32'h0000_0010, expInstret: 32'd1};
      vecs[1] = '{rdata: 32'h2042_0001, nextpc: 32'h0000_0012, expAddr: 32'h0000_0011, expInstret: 32'd2};
      vecs[2] = '{rdata: 32'h0800_0100, nextpc: 32'h0000_0100, expAddr: 32'h0000_0012, expInstret: 32'd3};
      vecs[3] = '{rdata: 32'h0000_0000, nextpc: 32'hFFFF_FFFF, expAddr: 32'h0000_0100, expInstret: 32'd4};

      rst_n = 1'b1;
      idleInputs();
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkReset("por");

      // Reset release, then abort in the middle of WAIT.
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("release.imemReq",  {31'd0, imemReq}, 32'd1);
      checkOutput("release.imemAddr", imemAddr,         32'h10);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkReset("midWait");
      rst_n = 1'b1;

      // Table-driven straight-line fetches, including the 3-cycle period.
      applyStimulus(vecs[0], "vec0", r0);
      applyStimulus(vecs[1], "vec1", r1);
      checkOutput("period", 32'(r1 - r0), 32'd3);
      for (int i = 2; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i), rTmp);

      // PC wrap to 0 with instret preloaded to its maximum.
      waitReq("wrap", rTmp);
      checkOutput("wrap.imemAddr", imemAddr, 32'hFFFF_FFFF);
      force dut.r_instret = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_instret;
      imemRvalid = 1'b1;
      imemRdata  = 32'h0800_0000;
      @(negedge clk);
      imemRvalid = 1'b0;
      checkOutput("wrap.pc",         pc,      32'hFFFF_FFFF);
      checkOutput("wrap.instretPre", instret, 32'hFFFF_FFFF);
      insReady = 1'b1;
      npcValid = 1'b1;
      nextpc   = 32'h0;
      @(negedge clk);
      idleInputs();
      checkOutput("wrap.instret", instret, 32'h0);
      waitReq("wrap2", rTmp);
      checkOutput("wrap.nextAddr", imemAddr, 32'h0);

      // Stall in ISSUE with a stray nextpc pulse, then late nextpc.
      @(negedge clk);
      imemRvalid = 1'b1;
      imemRdata  = 32'h8C22_0004;
      @(negedge clk);
      imemRvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         npcValid = (k == 2);
         nextpc   = (k == 2) ? 32'h77 : 32'h0;
         @(negedge clk);
         checkOutput($sformatf("stall%0d.insValid", k), {31'd0, insValid}, 32'd1);
         checkOutput($sformatf("stall%0d.ins", k),      ins,               32'h8C22_0004);
         checkOutput($sformatf("stall%0d.pc", k),       pc,                32'h0);
      end
      npcValid = 1'b0;
      insReady = 1'b1;
      @(negedge clk);
      insReady = 1'b0;
      checkOutput("stall.accepted", {31'd0, insValid}, 32'd0);
      checkOutput("stall.instret",  instret,           32'd1);
      @(negedge clk);
      checkOutput("npc.idleReq", {31'd0, imemReq}, 32'd0);
      npcValid = 1'b1;
      nextpc   = 32'h40;
      @(negedge clk);
      idleInputs();
      checkOutput("npc.imemReq",  {31'd0, imemReq}, 32'd1);
      checkOutput("npc.imemAddr", imemAddr,         32'h40);

      // Halt: sticky, counted, and no further requests.
      @(negedge clk);
      imemRvalid = 1'b1;
      imemRdata  = 32'hFC00_0000;
      @(negedge clk);
      imemRvalid = 1'b0;
      checkOutput("halt.ins", ins, 32'hFC00_0000);
      insReady = 1'b1;
      npcValid = 1'b1;
      nextpc   = 32'h50;
      @(negedge clk);
      checkOutput("halt.halted",   {31'd0, halted},   32'd1);
      checkOutput("halt.instret",  instret,           32'd2);
      checkOutput("halt.insValid", {31'd0, insValid}, 32'd0);
      reqSeen = 0;
      for (int k = 0; k < 6; k++) begin
         imemRvalid = k[0];
         @(negedge clk);
         if (imemReq !== 1'b0) reqSeen++;
      end
      idleInputs();
      checkOutput("halt.noReq",  32'(reqSeen),     32'd0);
      checkOutput("halt.sticky", {31'd0, halted},  32'd1);

      // Watchdog expiry after four WAIT cycles with no response.
      pulseReset();
      checkOutput("wd.resetTimeout", {31'd0, timeout}, 32'd0);
      waitReq("wd", rTmp);
      for (int k = 0; k < 4; k++) @(negedge clk);
      checkOutput("wd.notYet",  {31'd0, timeout}, 32'd0);
      @(negedge clk);
      checkOutput("wd.timeout", {31'd0, timeout}, 32'd1);
      imemRvalid = 1'b1;
      imemRdata  = 32'h1234_5678;
      reqSeen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (imemReq !== 1'b0 || insValid !== 1'b0) reqSeen++;
      end
      idleInputs();
      checkOutput("wd.terminal", 32'(reqSeen),     32'd0);
      checkOutput("wd.sticky",   {31'd0, timeout}, 32'd1);

      // Response on the expiry cycle wins over the timeout.
      pulseReset();
      waitReq("wdRace", rTmp);
      for (int k = 0; k < 4; k++) @(negedge clk);
      imemRvalid = 1'b1;
      imemRdata  = 32'h1234_5678;
      @(negedge clk);
      imemRvalid = 1'b0;
      checkOutput("wdRace.insValid", {31'd0, insValid}, 32'd1);
      checkOutput("wdRace.ins",      ins,               32'h1234_5678);
      checkOutput("wdRace.timeout",  {31'd0, timeout},  32'd0);
      @(negedge clk);
      checkOutput("wdRace.timeoutLater", {31'd0, timeout}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
